// File: rtl/pipeline_fg_coord_if.sv
// rtl/pipeline_fg_coord_if.sv - pixel coordinate in/out bundle for the foreground coordinate stage
interface pipeline_fg_coord_if #(
    parameter int PRECISION = 11
);
    logic                 in_valid;
    logic [PRECISION-1:0] in_x;
    logic [PRECISION-1:0] in_y;
    logic                 out_valid;
    logic [PRECISION-1:0] out_fg_x;
    logic [PRECISION-1:0] out_fg_y;
    logic                 out_fg_active;
    logic [1:0]           out_overlay_mode;

    modport master (
        output in_valid, in_x, in_y,
        input  out_valid, out_fg_x, out_fg_y, out_fg_active, out_overlay_mode
    );

    modport slave (
        input  in_valid, in_x, in_y,
        output out_valid, out_fg_x, out_fg_y, out_fg_active, out_overlay_mode
    );
endinterface

// File: rtl/pipeline_fg_coord.sv
// rtl/pipeline_fg_coord.sv - maps output pixel coordinates to foreground source coordinates, 3-cycle latency
module pipeline_fg_coord #(
    parameter int PRECISION = 11,
    parameter int FG_WIDTH  = 640,
    parameter int FG_HEIGHT = 480
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [1:0]                  ctrl_overlay_mode,
    input  logic [1:0]                  ctrl_fg_scale,
    input  logic signed [PRECISION:0]   ctrl_fg_offset_x,
    input  logic signed [PRECISION:0]   ctrl_fg_offset_y,
    input  logic [PRECISION-1:0]        ctrl_fg_clip_left,
    input  logic [PRECISION-1:0]        ctrl_fg_clip_right,
    input  logic [PRECISION-1:0]        ctrl_fg_clip_top,
    input  logic [PRECISION-1:0]        ctrl_fg_clip_bottom,
    input  logic                        frame_start,
    pipeline_fg_coord_if.slave          pix
);
    localparam int W = PRECISION + 2;
    localparam logic signed [W-1:0] FG_W = W'(FG_WIDTH);
    localparam logic signed [W-1:0] FG_H = W'(FG_HEIGHT);

    // Shadow copies of the control registers, stable for a whole frame
    logic [1:0]                sh_mode;
    logic [1:0]                sh_scale;
    logic signed [PRECISION:0] sh_off_x;
    logic signed [PRECISION:0] sh_off_y;
    logic [PRECISION-1:0]      sh_clip_l, sh_clip_r, sh_clip_t, sh_clip_b;

    // Stage 1: offset-subtracted coordinates plus the controls that go with this pixel
    logic                  s1_valid;
    logic signed [W-1:0]   s1_dx, s1_dy;
    logic [1:0]            s1_mode, s1_scale;
    logic [PRECISION-1:0]  s1_clip_l, s1_clip_r, s1_clip_t, s1_clip_b;

    // Stage 2: scaled coordinates
    logic                  s2_valid;
    logic signed [W-1:0]   s2_sx, s2_sy;
    logic [1:0]            s2_mode;
    logic [PRECISION-1:0]  s2_clip_l, s2_clip_r, s2_clip_t, s2_clip_b;

    logic signed [W-1:0]   dx_next, dy_next;
    logic signed [W-1:0]   bound_r, bound_b, lim_l, lim_t;
    logic                  active_next;

    // Latch live controls at the frame boundary; pixels on the same edge still see the old copy
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_mode   <= '0;
            sh_scale  <= '0;
            sh_off_x  <= '0;
            sh_off_y  <= '0;
            sh_clip_l <= '0;
            sh_clip_r <= '0;
            sh_clip_t <= '0;
            sh_clip_b <= '0;
        end else if (frame_start) begin
            sh_mode   <= ctrl_overlay_mode;
            sh_scale  <= ctrl_fg_scale;
            sh_off_x  <= ctrl_fg_offset_x;
            sh_off_y  <= ctrl_fg_offset_y;
            sh_clip_l <= ctrl_fg_clip_left;
            sh_clip_r <= ctrl_fg_clip_right;
            sh_clip_t <= ctrl_fg_clip_top;
            sh_clip_b <= ctrl_fg_clip_bottom;
        end
    end

    // Two extra bits of headroom make the subtraction overflow-free
    always_comb begin
        dx_next = $signed({2'b00, pix.in_x}) - $signed({sh_off_x[PRECISION], sh_off_x});
        dy_next = $signed({2'b00, pix.in_y}) - $signed({sh_off_y[PRECISION], sh_off_y});
    end

    // Stage 1 register: offset subtraction
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_dx     <= '0;
            s1_dy     <= '0;
            s1_mode   <= '0;
            s1_scale  <= '0;
            s1_clip_l <= '0;
            s1_clip_r <= '0;
            s1_clip_t <= '0;
            s1_clip_b <= '0;
        end else begin
            s1_valid  <= pix.in_valid;
            s1_dx     <= dx_next;
            s1_dy     <= dy_next;
            s1_mode   <= sh_mode;
            s1_scale  <= sh_scale;
            s1_clip_l <= sh_clip_l;
            s1_clip_r <= sh_clip_r;
            s1_clip_t <= sh_clip_t;
            s1_clip_b <= sh_clip_b;
        end
    end

    // Stage 2 register: arithmetic downscale keeps negative coordinates negative
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid  <= 1'b0;
            s2_sx     <= '0;
            s2_sy     <= '0;
            s2_mode   <= '0;
            s2_clip_l <= '0;
            s2_clip_r <= '0;
            s2_clip_t <= '0;
            s2_clip_b <= '0;
        end else begin
            s2_valid  <= s1_valid;
            s2_sx     <= s1_dx >>> s1_scale;
            s2_sy     <= s1_dy >>> s1_scale;
            s2_mode   <= s1_mode;
            s2_clip_l <= s1_clip_l;
            s2_clip_r <= s1_clip_r;
            s2_clip_t <= s1_clip_t;
            s2_clip_b <= s1_clip_b;
        end
    end

    // Visibility window: clip bounds are signed so an oversized clip simply empties the window
    always_comb begin
        lim_l   = $signed({2'b00, s2_clip_l});
        lim_t   = $signed({2'b00, s2_clip_t});
        bound_r = FG_W - $signed({2'b00, s2_clip_r});
        bound_b = FG_H - $signed({2'b00, s2_clip_b});
        active_next = (s2_mode != 2'd0)
                    && (s2_sx >= lim_l) && (s2_sx < bound_r)
                    && (s2_sy >= lim_t) && (s2_sy < bound_b)
                    && (s2_sx >= 0) && (s2_sy >= 0)
                    && (s2_sx < FG_W) && (s2_sy < FG_H);
    end

    // Stage 3 register: outputs, coordinates forced to zero unless the foreground is shown
    always_ff @(posedge clk) begin
        if (rst) begin
            pix.out_valid        <= 1'b0;
            pix.out_fg_active    <= 1'b0;
            pix.out_fg_x         <= '0;
            pix.out_fg_y         <= '0;
            pix.out_overlay_mode <= '0;
        end else begin
            pix.out_valid        <= s2_valid;
            pix.out_fg_active    <= s2_valid && active_next;
            pix.out_fg_x         <= (s2_valid && active_next) ? s2_sx[PRECISION-1:0] : '0;
            pix.out_fg_y         <= (s2_valid && active_next) ? s2_sy[PRECISION-1:0] : '0;
            pix.out_overlay_mode <= s2_valid ? s2_mode : 2'd0;
        end
    end
endmodule

// File: tb/tb_pipeline_fg_coord.sv
// tb/tb_pipeline_fg_coord.sv - scoreboard bench for pipeline_fg_coord
module tb_pipeline_fg_coord;
    localparam int P = 11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0]         ctrl_overlay_mode = '0;
    logic [1:0]         ctrl_fg_scale = '0;
    logic signed [P:0]  ctrl_fg_offset_x = '0;
    logic signed [P:0]  ctrl_fg_offset_y = '0;
    logic [P-1:0]       ctrl_fg_clip_left = '0;
    logic [P-1:0]       ctrl_fg_clip_right = '0;
    logic [P-1:0]       ctrl_fg_clip_top = '0;
    logic [P-1:0]       ctrl_fg_clip_bottom = '0;
    logic               frame_start = 1'b0;

    pipeline_fg_coord_if #(.PRECISION(P)) pix ();

    pipeline_fg_coord #(.PRECISION(P), .FG_WIDTH(640), .FG_HEIGHT(480)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .ctrl_overlay_mode   (ctrl_overlay_mode),
        .ctrl_fg_scale       (ctrl_fg_scale),
        .ctrl_fg_offset_x    (ctrl_fg_offset_x),
        .ctrl_fg_offset_y    (ctrl_fg_offset_y),
        .ctrl_fg_clip_left   (ctrl_fg_clip_left),
        .ctrl_fg_clip_right  (ctrl_fg_clip_right),
        .ctrl_fg_clip_top    (ctrl_fg_clip_top),
        .ctrl_fg_clip_bottom (ctrl_fg_clip_bottom),
        .frame_start         (frame_start),
        .pix                 (pix.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        int x;
        int y;
        int act;
        int mode;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    // Reference copy of the shadow registers
    int m_mode, m_scale, m_ox, m_oy, m_cl, m_cr, m_ct, m_cb;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic exp_t model(input int x, input int y);
        exp_t e;
        int sx, sy;
        bit act;
        sx = (x - m_ox) >>> m_scale;
        sy = (y - m_oy) >>> m_scale;
        act = (m_mode != 0) && (sx >= m_cl) && (sx < 640 - m_cr) && (sy >= m_ct) && (sy < 480 - m_cb)
            && (sx >= 0) && (sy >= 0) && (sx < 640) && (sy < 480);
        e.due  = 0;
        e.act  = act ? 1 : 0;
        e.x    = act ? sx : 0;
        e.y    = act ? sy : 0;
        e.mode = m_mode;
        return e;
    endfunction

    task automatic set_ctrl(input int mode, input int scale, input int ox, input int oy,
                            input int cl, input int cr, input int ct, input int cb);
        ctrl_overlay_mode   = mode[1:0];
        ctrl_fg_scale       = scale[1:0];
        ctrl_fg_offset_x    = ox[P:0];
        ctrl_fg_offset_y    = oy[P:0];
        ctrl_fg_clip_left   = cl[P-1:0];
        ctrl_fg_clip_right  = cr[P-1:0];
        ctrl_fg_clip_top    = ct[P-1:0];
        ctrl_fg_clip_bottom = cb[P-1:0];
    endtask

    task automatic step(input bit fs, input bit v, input int x, input int y);
        exp_t e;
        @(negedge clk);
        frame_start  = fs;
        pix.in_valid = v;
        pix.in_x     = x[P-1:0];
        pix.in_y     = y[P-1:0];
        if (v) begin
            e = model(x, y);
            e.due = cyc + 3;
            q.push_back(e);
        end
        if (fs) begin
            m_mode  = int'(ctrl_overlay_mode);
            m_scale = int'(ctrl_fg_scale);
            m_ox    = int'(ctrl_fg_offset_x);
            m_oy    = int'(ctrl_fg_offset_y);
            m_cl    = int'(ctrl_fg_clip_left);
            m_cr    = int'(ctrl_fg_clip_right);
            m_ct    = int'(ctrl_fg_clip_top);
            m_cb    = int'(ctrl_fg_clip_bottom);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        frame_start  = 1'b0;
        pix.in_valid = 1'b0;
        while (q.size() > 0 && q[q.size()-1].due >= cyc + 1) void'(q.pop_back());
        m_mode = 0; m_scale = 0; m_ox = 0; m_oy = 0; m_cl = 0; m_cr = 0; m_ct = 0; m_cb = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: every cycle, the output must match the scoreboard head exactly when it is due
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (q.size() > 0 && q[0].due == cyc) begin
                check("out_valid", int'(pix.out_valid), 1);
                check("out_fg_active", int'(pix.out_fg_active), q[0].act);
                check("out_fg_x", int'(pix.out_fg_x), q[0].x);
                check("out_fg_y", int'(pix.out_fg_y), q[0].y);
                check("out_overlay_mode", int'(pix.out_overlay_mode), q[0].mode);
                void'(q.pop_front());
            end else if (!rst) begin
                check("bubble_valid", int'(pix.out_valid), 0);
                check("bubble_active", int'(pix.out_fg_active), 0);
                check("bubble_fg_x", int'(pix.out_fg_x), 0);
            end
        end
    end

    initial begin
        pix.in_valid = 1'b0;
        pix.in_x = '0;
        pix.in_y = '0;
        m_mode = 0; m_scale = 0; m_ox = 0; m_oy = 0; m_cl = 0; m_cr = 0; m_ct = 0; m_cb = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_out_valid", int'(pix.out_valid), 0);
        check("rst_out_active", int'(pix.out_fg_active), 0);
        check("rst_out_x", int'(pix.out_fg_x), 0);
        check("rst_out_y", int'(pix.out_fg_y), 0);
        check("rst_out_mode", int'(pix.out_overlay_mode), 0);

        // Identity mapping
        set_ctrl(1, 0, 0, 0, 0, 0, 0, 0);
        step(1'b1, 1'b0, 0, 0);
        step(1'b0, 1'b1, 100, 50);
        idle(4);

        // Offset and scale, including a negative dx
        set_ctrl(2, 1, 200, -40, 0, 0, 0, 0);
        step(1'b1, 1'b0, 0, 0);
        step(1'b0, 1'b1, 300, 0);
        step(1'b0, 1'b1, 199, 0);
        idle(4);

        // Clip edges, then an oversized right clip
        set_ctrl(1, 0, 0, 0, 10, 20, 0, 0);
        step(1'b1, 1'b0, 0, 0);
        step(1'b0, 1'b1, 9, 0);
        step(1'b0, 1'b1, 10, 0);
        step(1'b0, 1'b1, 619, 0);
        step(1'b0, 1'b1, 620, 0);
        set_ctrl(1, 0, 0, 0, 0, 700, 0, 0);
        step(1'b1, 1'b0, 0, 0);
        step(1'b0, 1'b1, 0, 0);
        step(1'b0, 1'b1, 100, 0);
        step(1'b0, 1'b1, 639, 479);
        idle(4);

        // Shadow timing: live change mid-frame, then frame_start alongside a pixel
        set_ctrl(3, 0, 0, 0, 0, 0, 0, 0);
        step(1'b1, 1'b0, 0, 0);
        step(1'b0, 1'b1, 50, 7);
        set_ctrl(3, 0, 5, 0, 0, 0, 0, 0);
        step(1'b0, 1'b1, 50, 7);
        step(1'b1, 1'b1, 50, 7);
        step(1'b0, 1'b1, 50, 7);
        idle(4);

        // Streaming with a bubble
        set_ctrl(1, 0, 0, 0, 0, 0, 0, 0);
        step(1'b1, 1'b0, 0, 0);
        step(1'b0, 1'b1, 0, 0);
        step(1'b0, 1'b1, 1, 0);
        step(1'b0, 1'b0, 2, 0);
        step(1'b0, 1'b1, 3, 0);
        idle(4);

        // Randomised frames
        for (int f = 0; f < 6; f++) begin
            set_ctrl($urandom_range(3, 0), $urandom_range(3, 0),
                     int'($urandom_range(600, 0)) - 300, int'($urandom_range(600, 0)) - 300,
                     $urandom_range(100, 0), $urandom_range(100, 0),
                     $urandom_range(100, 0), $urandom_range(100, 0));
            step(1'b1, 1'b0, 0, 0);
            for (int i = 0; i < 25; i++)
                step(1'b0, 1'($urandom_range(3, 0) != 0), $urandom_range(1000, 0), $urandom_range(700, 0));
        end
        idle(4);

        // Reset with pixels in flight; shadow mode returns to 0
        set_ctrl(1, 0, 0, 0, 0, 0, 0, 0);
        step(1'b1, 1'b0, 0, 0);
        step(1'b0, 1'b1, 20, 20);
        step(1'b0, 1'b1, 21, 20);
        step(1'b0, 1'b1, 22, 20);
        do_reset();
        idle(4);
        step(1'b0, 1'b1, 10, 10);
        idle(6);

        check("scoreboard_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
